// File: rtl/sriz_mc_ctrl.sv
// Multi-cycle fetch/execute/memory/writeback sequencer for the sriz core.
// Owns the PC and instruction latch; raises sticky halt/fault on ebreak, bus error, timeout or misaligned PC.
module sriz_mc_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned     TIMEOUT  = 255,
    parameter int unsigned     CNT_W    = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             if_req_valid_o,
    input  logic             if_req_ready_i,
    output logic [XLEN-1:0]  if_addr_o,
    input  logic             if_rsp_valid_i,
    input  logic [31:0]      if_rsp_inst_i,
    input  logic             if_rsp_err_i,
    output logic [31:0]      inst_o,
    output logic [XLEN-1:0]  pc_o,
    input  logic             dec_load_i,
    input  logic             dec_store_i,
    input  logic             dec_jump_i,
    input  logic             dec_rd_wen_i,
    input  logic             dec_brk_i,
    input  logic [XLEN-1:0]  next_pc_i,
    output logic             ls_req_valid_o,
    input  logic             ls_req_ready_i,
    input  logic             ls_rsp_valid_i,
    input  logic             ls_rsp_err_i,
    output logic             rsp_ready_o,
    output logic             reg_wen_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [1:0]       fault_cause_o,
    output logic [CNT_W-1:0] minstret_o
);

    // state   | meaning
    // IDLE    | first cycle after reset, PC alignment check
    // IF_REQ  | fetch request offered at pc
    // IF_WAIT | waiting for the instruction response
    // EXEC    | decode/EXU settle, pick next step
    // LS_REQ  | data request offered
    // LS_WAIT | waiting for the data response
    // WB      | register write strobe, PC update, retire
    // HALT    | ebreak retired, frozen until reset
    // FAULT   | error, frozen until reset
    typedef enum logic [3:0] {
        IDLE, IF_REQ, IF_WAIT, EXEC, LS_REQ, LS_WAIT, WB, HALT, FAULT
    } state_e;

    localparam int unsigned TW          = $clog2(TIMEOUT + 1) + 1;
    localparam logic [1:0]  CAUSE_BUS   = 2'd1;
    localparam logic [1:0]  CAUSE_TMO   = 2'd2;
    localparam logic [1:0]  CAUSE_ALIGN = 2'd3;

    state_e           state_q;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [31:0]      inst_q;
    logic [CNT_W-1:0] minstret_q, minstret_d;
    logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             halted_q, fault_q;
    logic [1:0]       cause_q;
    logic             tmo_hit;

    always_comb begin
        pc_d       = dec_jump_i ? next_pc_i : pc_q + XLEN'(4);
        minstret_d = minstret_q + CNT_W'(1);
        wait_cnt_d = wait_cnt_q + TW'(1);
        tmo_hit    = (TIMEOUT != 0) && (wait_cnt_d == TW'(TIMEOUT));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            minstret_q <= '0;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            cause_q    <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pc_q[1:0] != 2'b00) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                        cause_q <= CAUSE_ALIGN;
                    end else begin
                        state_q <= IF_REQ;
                    end
                end
                IF_REQ: begin
                    if (if_req_ready_i) begin
                        state_q    <= IF_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                IF_WAIT: begin
                    // A response in the limit cycle is taken before the timeout.
                    if (if_rsp_valid_i) begin
                        if (if_rsp_err_i) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                            cause_q <= CAUSE_BUS;
                        end else begin
                            inst_q  <= if_rsp_inst_i;
                            state_q <= EXEC;
                        end
                    end else if (tmo_hit) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                        cause_q <= CAUSE_TMO;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                EXEC: begin
                    if (dec_brk_i) begin
                        state_q    <= HALT;
                        halted_q   <= 1'b1;
                        minstret_q <= minstret_d;
                    end else if (dec_load_i || dec_store_i) begin
                        state_q <= LS_REQ;
                    end else begin
                        state_q <= WB;
                    end
                end
                LS_REQ: begin
                    if (ls_req_ready_i) begin
                        state_q    <= LS_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                LS_WAIT: begin
                    if (ls_rsp_valid_i) begin
                        if (ls_rsp_err_i) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                            cause_q <= CAUSE_BUS;
                        end else begin
                            state_q <= WB;
                        end
                    end else if (tmo_hit) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                        cause_q <= CAUSE_TMO;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                WB: begin
                    pc_q       <= pc_d;
                    minstret_q <= minstret_d;
                    if (pc_d[1:0] != 2'b00) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                        cause_q <= CAUSE_ALIGN;
                    end else begin
                        state_q <= IF_REQ;
                    end
                end
                HALT:    state_q <= HALT;
                FAULT:   state_q <= FAULT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_req_valid_o = (state_q == IF_REQ);
    assign ls_req_valid_o = (state_q == LS_REQ);
    assign rsp_ready_o    = (state_q == IF_WAIT) || (state_q == LS_WAIT);
    assign reg_wen_o      = (state_q == WB) && dec_rd_wen_i && !dec_store_i;
    assign if_addr_o      = pc_q;
    assign pc_o           = pc_q;
    assign inst_o         = inst_q;
    assign minstret_o     = minstret_q;
    assign halted_o       = halted_q;
    assign fault_o        = fault_q;
    assign fault_cause_o  = cause_q;

endmodule

// File: tb/tb_sriz_mc_ctrl.sv
// Bench for sriz_mc_ctrl: reactive memory model per instruction, fetch-address scoreboard,
// per-feature tasks with inline checks.
module tb_sriz_mc_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int NO_RSP     = 1000;
    localparam int END_NEXT   = 0;
    localparam int END_HALT   = 1;
    localparam int END_FAULT  = 2;
    localparam int END_BUDGET = 3;
    localparam int END_ABORT  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_addr, if_rsp_inst, inst, pc, next_pc;
    logic        dec_load, dec_store, dec_jump, dec_rd_wen, dec_brk;
    logic        ls_req_valid, ls_req_ready, ls_rsp_valid, ls_rsp_err;
    logic        rsp_ready, reg_wen, halted, fault;
    logic [1:0]  fault_cause;
    logic [63:0] minstret;

    sriz_mc_ctrl #(.XLEN(32), .RESET_PC(32'h8000_0000), .TIMEOUT(4), .CNT_W(64)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_valid_o(if_req_valid), .if_req_ready_i(if_req_ready), .if_addr_o(if_addr),
        .if_rsp_valid_i(if_rsp_valid), .if_rsp_inst_i(if_rsp_inst), .if_rsp_err_i(if_rsp_err),
        .inst_o(inst), .pc_o(pc),
        .dec_load_i(dec_load), .dec_store_i(dec_store), .dec_jump_i(dec_jump),
        .dec_rd_wen_i(dec_rd_wen), .dec_brk_i(dec_brk), .next_pc_i(next_pc),
        .ls_req_valid_o(ls_req_valid), .ls_req_ready_i(ls_req_ready),
        .ls_rsp_valid_i(ls_rsp_valid), .ls_rsp_err_i(ls_rsp_err),
        .rsp_ready_o(rsp_ready), .reg_wen_o(reg_wen), .halted_o(halted), .fault_o(fault),
        .fault_cause_o(fault_cause), .minstret_o(minstret)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] tb_inst = 32'h0000_0013;
    int r_cycles, r_wen, r_lsv, r_ifwait, r_lswait, r_end;
    bit r_addr_moved, r_pc_moved;
    logic [31:0] sb_exp, sb_obs;

    task automatic clear_inputs();
        if_req_ready = 0; if_rsp_valid = 0; if_rsp_err = 0; if_rsp_inst = 32'hDEAD_BEEF;
        ls_req_ready = 0; ls_rsp_valid = 0; ls_rsp_err = 0;
        dec_load = 0; dec_store = 0; dec_jump = 0; dec_rd_wen = 0; dec_brk = 0; next_pc = '0;
    endtask

    // Leaves time just after a negedge with the DUT in IF_REQ.
    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // Drives one instruction as memory model and IDU; starts and returns at a negedge.
    task automatic run_instr(input int if_rdy, input int if_rsp, input bit if_err,
                             input bit ld, input bit st, input bit jmp, input logic [31:0] npc,
                             input bit rdw, input bit brk, input int ls_rdy, input int ls_rsp,
                             input bit ls_err, input bit abort_ls);
        int phase = 0;
        int ifq = 0, ifw = 0, lsq = 0, lsw = 0;
        logic [31:0] a0 = '0;
        logic [31:0] p0;
        bit done = 0;
        p0 = pc;
        dec_load = ld; dec_store = st; dec_jump = jmp; next_pc = npc; dec_rd_wen = rdw; dec_brk = brk;
        r_cycles = 0; r_wen = 0; r_lsv = 0; r_ifwait = 0; r_lswait = 0; r_end = END_NEXT;
        r_addr_moved = 0; r_pc_moved = 0;
        while (!done) begin
            if_req_ready = 0; if_rsp_valid = 0; if_rsp_err = 0; if_rsp_inst = 32'hDEAD_BEEF;
            ls_req_ready = 0; ls_rsp_valid = 0; ls_rsp_err = 0;
            if (fault) begin r_end = END_FAULT; done = 1; end
            else if (halted) begin r_end = END_HALT; done = 1; end
            else if (phase >= 2 && if_req_valid) begin r_end = END_NEXT; done = 1; end
            else if (r_cycles >= 300) begin r_end = END_BUDGET; done = 1; end
            else begin
                r_cycles++;
                if (if_req_valid) begin
                    ifq++;
                    if (ifq == 1) a0 = if_addr;
                    else if (if_addr !== a0) r_addr_moved = 1;
                    if (ifq > if_rdy) begin if_req_ready = 1; obs_q.push_back(if_addr); phase = 1; end
                end else if (rsp_ready && phase == 1) begin
                    ifw++; r_ifwait = ifw;
                    if (ifw > if_rsp) begin
                        if_rsp_valid = 1; if_rsp_err = if_err; if_rsp_inst = tb_inst; phase = 2;
                    end
                end else if (ls_req_valid) begin
                    lsq++; r_lsv = lsq;
                    if (pc !== p0) r_pc_moved = 1;
                    if (lsq > ls_rdy) begin ls_req_ready = 1; phase = 3; end
                end else if (rsp_ready && phase == 3) begin
                    lsw++; r_lswait = lsw;
                    if (abort_ls && lsw == 2) begin
                        #2 rst_n = 0;
                        r_end = END_ABORT; done = 1;
                    end else if (lsw > ls_rsp) begin
                        ls_rsp_valid = 1; ls_rsp_err = ls_err; phase = 2;
                    end
                end
                if (!done) begin
                    #1;
                    if (reg_wen) r_wen++;
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pc !== RST_PC || inst !== 32'h0 || minstret !== 64'h0) begin
            n_bad++; $display("FAIL reset_regs: pc=%h inst=%h minstret=%0d want %h/0/0", pc, inst, minstret, RST_PC);
        end
        n_cmp++;
        if ({if_req_valid, ls_req_valid, reg_wen, rsp_ready, halted, fault, fault_cause} !== 8'h0) begin
            n_bad++; $display("FAIL reset_outs: got %b want 0", {if_req_valid, ls_req_valid, reg_wen, rsp_ready, halted, fault, fault_cause});
        end
        rst_n = 1;
        #1;
        n_cmp++;
        if (if_req_valid !== 1'b0) begin n_bad++; $display("FAIL idle_no_req: got %b want 0", if_req_valid); end
        @(negedge clk);
        n_cmp++;
        if (if_req_valid !== 1'b1 || if_addr !== RST_PC) begin
            n_bad++; $display("FAIL first_fetch: valid=%b addr=%h want 1/%h", if_req_valid, if_addr, RST_PC);
        end
    endtask

    task automatic test_alu();
        int wen_total = 0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(RST_PC + 32'(4 * i));
            run_instr(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
            wen_total += r_wen;
            n_cmp++;
            if (r_cycles != 4 || r_end != END_NEXT) begin
                n_bad++; $display("FAIL alu_cycles[%0d]: got %0d end %0d want 4 end 0", i, r_cycles, r_end);
            end
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL alu_fetch[%0d]: got none want %h", i, exp_q[0]); void'(exp_q.pop_front()); end
            else begin
                sb_obs = obs_q.pop_front(); sb_exp = exp_q.pop_front();
                if (sb_obs !== sb_exp) begin n_bad++; $display("FAIL alu_fetch[%0d]: got %h want %h", i, sb_obs, sb_exp); end
            end
        end
        n_cmp++;
        if (pc !== RST_PC + 32'd12) begin n_bad++; $display("FAIL alu_pc: got %h want %h", pc, RST_PC + 32'd12); end
        n_cmp++;
        if (minstret !== 64'd3 || wen_total != 3) begin
            n_bad++; $display("FAIL alu_retire: minstret=%0d wen=%0d want 3/3", minstret, wen_total);
        end
    endtask

    task automatic test_load();
        tb_inst = 32'h0000_2083;
        exp_q.push_back(32'h8000_000C);
        run_instr(0, 0, 0, 1, 0, 0, 32'h0, 1, 0, 5, 3, 0, 0);
        n_cmp++;
        if (r_lsv != 6 || r_pc_moved) begin
            n_bad++; $display("FAIL load_req_hold: cycles=%0d moved=%0b want 6/0", r_lsv, r_pc_moved);
        end
        n_cmp++;
        if (r_end != END_NEXT || r_lswait != 4 || fault !== 1'b0) begin
            n_bad++; $display("FAIL load_rsp_at_limit: end=%0d wait=%0d fault=%b want 0/4/0", r_end, r_lswait, fault);
        end
        n_cmp++;
        if (r_wen != 1) begin n_bad++; $display("FAIL load_wen: got %0d want 1", r_wen); end
        n_cmp++;
        if (inst !== 32'h0000_2083 || minstret !== 64'd4 || pc !== 32'h8000_0010) begin
            n_bad++; $display("FAIL load_state: inst=%h minstret=%0d pc=%h want 00002083/4/80000010", inst, minstret, pc);
        end
        n_cmp++;
        if (obs_q.size() == 0) begin n_bad++; $display("FAIL load_fetch: got none want 8000000c"); void'(exp_q.pop_front()); end
        else begin
            sb_obs = obs_q.pop_front(); sb_exp = exp_q.pop_front();
            if (sb_obs !== sb_exp) begin n_bad++; $display("FAIL load_fetch: got %h want %h", sb_obs, sb_exp); end
        end
    endtask

    task automatic test_jump();
        bit bad_idle = 0;
        exp_q.push_back(32'h8000_0010);
        exp_q.push_back(32'h8000_0100);
        run_instr(0, 0, 0, 0, 0, 1, 32'h8000_0100, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pc !== 32'h8000_0100 || r_end != END_NEXT) begin
            n_bad++; $display("FAIL jump_pc: got %h end %0d want 80000100 end 0", pc, r_end);
        end
        run_instr(0, 0, 0, 0, 0, 1, 32'h8000_0102, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL jump_fetch[%0d]: got none want %h", i, exp_q[0]); void'(exp_q.pop_front()); end
            else begin
                sb_obs = obs_q.pop_front(); sb_exp = exp_q.pop_front();
                if (sb_obs !== sb_exp) begin n_bad++; $display("FAIL jump_fetch[%0d]: got %h want %h", i, sb_obs, sb_exp); end
            end
        end
        n_cmp++;
        if (r_end != END_FAULT || fault_cause !== 2'd3 || r_wen != 1 || minstret !== 64'd6) begin
            n_bad++; $display("FAIL misalign_jump: end=%0d cause=%0d wen=%0d minstret=%0d want 2/3/1/6", r_end, fault_cause, r_wen, minstret);
        end
        repeat (6) begin
            @(negedge clk);
            if (if_req_valid || ls_req_valid || reg_wen || fault_cause !== 2'd3) bad_idle = 1;
        end
        n_cmp++;
        if (bad_idle) begin n_bad++; $display("FAIL fault_frozen: got activity want none, cause %0d want 3", fault_cause); end
    endtask

    task automatic test_fetch_err();
        do_reset();
        run_instr(2, 1, 1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
        void'(obs_q.pop_front());
        n_cmp++;
        if (r_end != END_FAULT || fault_cause !== 2'd1 || r_ifwait != 2 || r_addr_moved || inst !== 32'h0) begin
            n_bad++; $display("FAIL fetch_err: end=%0d cause=%0d wait=%0d moved=%0b inst=%h want 2/1/2/0/0", r_end, fault_cause, r_ifwait, r_addr_moved, inst);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run_instr(0, NO_RSP, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
        void'(obs_q.pop_front());
        n_cmp++;
        if (r_end != END_FAULT || fault_cause !== 2'd2 || r_ifwait != 4) begin
            n_bad++; $display("FAIL timeout: end=%0d cause=%0d wait=%0d want 2/2/4", r_end, fault_cause, r_ifwait);
        end
        do_reset();
        run_instr(0, 3, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
        void'(obs_q.pop_front());
        n_cmp++;
        if (r_end != END_NEXT || fault !== 1'b0 || r_ifwait != 4 || minstret !== 64'd1) begin
            n_bad++; $display("FAIL timeout_rsp_wins: end=%0d fault=%b wait=%0d minstret=%0d want 0/0/4/1", r_end, fault, r_ifwait, minstret);
        end
    endtask

    task automatic test_ebreak();
        bit bad_idle = 0;
        do_reset();
        run_instr(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0);
        obs_q.delete();
        n_cmp++;
        if (r_end != END_HALT || halted !== 1'b1 || minstret !== 64'd3 || pc !== RST_PC + 32'd8) begin
            n_bad++; $display("FAIL ebreak: end=%0d halted=%b minstret=%0d pc=%h want 1/1/3/%h", r_end, halted, minstret, pc, RST_PC + 32'd8);
        end
        repeat (8) begin
            @(negedge clk);
            if (if_req_valid || ls_req_valid || pc !== RST_PC + 32'd8 || minstret !== 64'd3) bad_idle = 1;
        end
        n_cmp++;
        if (bad_idle) begin n_bad++; $display("FAIL halt_frozen: got activity want none"); end
        rst_n = 0;
        #1;
        n_cmp++;
        if (pc !== RST_PC || halted !== 1'b0) begin
            n_bad++; $display("FAIL halt_reset: pc=%h halted=%b want %h/0", pc, halted, RST_PC);
        end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        exp_q.push_back(RST_PC);
        run_instr(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_q.size() == 0) begin n_bad++; $display("FAIL resume_fetch: got none want %h", RST_PC); void'(exp_q.pop_front()); end
        else begin
            sb_obs = obs_q.pop_front(); sb_exp = exp_q.pop_front();
            if (sb_obs !== sb_exp || r_end != END_NEXT) begin
                n_bad++; $display("FAIL resume_fetch: got %h end %0d want %h end 0", sb_obs, r_end, sb_exp);
            end
        end
    endtask

    task automatic test_store();
        do_reset();
        run_instr(0, 0, 0, 0, 1, 0, 32'h0, 1, 0, 0, 0, 1, 0);
        void'(obs_q.pop_front());
        n_cmp++;
        if (r_end != END_FAULT || fault_cause !== 2'd1 || r_wen != 0) begin
            n_bad++; $display("FAIL store_err: end=%0d cause=%0d wen=%0d want 2/1/0", r_end, fault_cause, r_wen);
        end
        do_reset();
        run_instr(0, 0, 0, 0, 1, 0, 32'h0, 1, 0, 0, NO_RSP, 0, 1);
        void'(obs_q.pop_front());
        #1;
        n_cmp++;
        if (r_end != END_ABORT || {if_req_valid, ls_req_valid, rsp_ready, reg_wen, halted, fault, fault_cause} !== 8'h0
            || pc !== RST_PC || inst !== 32'h0 || minstret !== 64'h0) begin
            n_bad++; $display("FAIL async_reset_lswait: end=%0d outs=%b pc=%h want 4/0/%h", r_end,
                {if_req_valid, ls_req_valid, rsp_ready, reg_wen, halted, fault, fault_cause}, pc, RST_PC);
        end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        run_instr(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
        void'(obs_q.pop_front());
        n_cmp++;
        if (r_end != END_NEXT || minstret !== 64'd1 || fault !== 1'b0) begin
            n_bad++; $display("FAIL after_abort: end=%0d minstret=%0d fault=%b want 0/1/0", r_end, minstret, fault);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_jump();
        test_fetch_err();
        test_timeout();
        test_ebreak();
        test_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sriz_mc_ctrl.md
Name: sriz_mc_ctrl

Overview:
- Multi-cycle sequencer for the next-generation sriz core. It replaces the always-enabled PC and single-cycle datapath timing.
- Owns the PC, latches the fetched instruction, and steps fetch/execute/memory/writeback through an FSM.
- Talks to instruction and data memories over valid/ready request/response handshakes with arbitrary latency.
- Adds bus timeout, misaligned-PC fault, ebreak halt and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h80000000, PC value loaded on reset.
- TIMEOUT, 255, maximum cycles spent in any WAIT state before a fault. 0 disables the timeout.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- if_req_valid  out  1  instruction fetch request valid.
- if_req_ready  in  1  instruction memory accepts the request.
- if_addr  out  XLEN  fetch address; equals pc.
- if_rsp_valid  in  1  instruction response valid.
- if_rsp_inst  in  32  fetched instruction.
- if_rsp_err  in  1  fetch bus error; qualified by if_rsp_valid.
- inst  out  32  latched instruction fed to the IDU.
- pc  out  XLEN  current PC.
- dec_load  in  1  IDU: current instruction is a load.
- dec_store  in  1  IDU: current instruction is a store.
- dec_jump  in  1  IDU: take next_pc (jump or taken branch).
- dec_rd_wen  in  1  IDU: instruction writes rd.
- dec_brk  in  1  IDU: ebreak.
- next_pc  in  XLEN  EXU computed target.
- ls_req_valid  out  1  data memory request valid.
- ls_req_ready  in  1  data memory accepts the request.
- ls_rsp_valid  in  1  data response valid.
- ls_rsp_err  in  1  data bus error; qualified by ls_rsp_valid.
- rsp_ready  out  1  high in both WAIT states; otherwise low.
- reg_wen  out  1  one-cycle register-file write strobe.
- halted  out  1  sticky; ebreak retired.
- fault  out  1  sticky; core stopped on an error.
- fault_cause  out  2  0 = none, 1 = bus error, 2 = timeout, 3 = misaligned PC.
- minstret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, pc = RESET_PC, inst = 0, minstret = 0.
  - All valid and strobe outputs are 0, halted = 0, fault = 0, fault_cause = 0.
  - Reset asserted mid-transaction abandons the transaction immediately; no response is awaited afterwards.
- FSM states: IDLE, IF_REQ, IF_WAIT, EXEC, LS_REQ, LS_WAIT, WB, HALT, FAULT.
- IDLE:
  - Goes to IF_REQ on the first clock after rst deasserts.
  - Misaligned check: if pc[1:0] != 0, go to FAULT with cause 3 instead.
- IF_REQ:
  - if_req_valid = 1; if_addr holds stable until if_req_ready.
  - On valid & ready, go to IF_WAIT.
  - Responses are ignored in REQ states. The earliest response is therefore one cycle after the handshake.
- IF_WAIT:
  - On if_rsp_valid with err = 0: latch inst and go to EXEC.
  - On if_rsp_valid with err = 1: go to FAULT, cause 1.
- EXEC (one cycle; decode and EXU settle):
  - dec_brk: go to HALT; minstret += 1.
  - Else if dec_load or dec_store: go to LS_REQ.
  - Else: go to WB.
- LS_REQ / LS_WAIT: same handshake rules as fetch. ls_rsp_err = 1 → FAULT, cause 1.
- WB (one cycle):
  - reg_wen = dec_rd_wen & ~dec_store.
  - pc <= dec_jump ? next_pc : pc + 4. Addition is modulo 2^XLEN; wrap-around is allowed.
  - minstret += 1, wrapping modulo 2^CNT_W.
  - Next state is IF_REQ. If the new pc[1:0] != 0, go to FAULT with cause 3 instead; reg_wen is still issued because the instruction retired.
- Timeout:
  - A wait counter clears on entry to each WAIT state and increments every cycle while waiting.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT without a response, go to FAULT, cause 2.
  - A response arriving in the same cycle as the limit wins: it is accepted normally and no fault is raised.
- HALT and FAULT are terminal until reset.
  - No requests are issued; pc, inst and minstret are frozen.
  - halted or fault stays 1; fault_cause is written once and is sticky.
- reg_wen is never asserted outside WB. At most one of if_req_valid and ls_req_valid is high in any cycle.

Test Plan:
- Zero-latency memories, 3 ALU instructions (dec_jump = 0):
  - IF_REQ→IF_WAIT→EXEC→WB takes 4 cycles per instruction.
  - pc goes 0x80000000, 0x80000004, 0x80000008, 0x8000000C.
  - minstret = 3 and reg_wen pulses 3 times.
- Load with ls_req_ready delayed 5 cycles and response delayed 3:
  - ls_req_valid is held 6 cycles with address unchanged.
  - reg_wen fires exactly once, in WB after the response.
- Jump with next_pc = 0x80000100: next if_addr = 0x80000100. With next_pc = 0x80000102: FAULT, cause 3, reg_wen still pulses once.
- TIMEOUT = 4, if_rsp_valid held 0:
  - fault = 1, cause 2, exactly 4 cycles after entering IF_WAIT.
  - Repeat with the response arriving on cycle 4: no fault.
- ebreak after 2 instructions:
  - halted = 1, minstret = 3, no further if_req_valid.
  - Pulsing rst low restores pc = 0x80000000, halted = 0, and fetch resumes.
- Store with ls_rsp_err = 1: fault = 1, cause 1, no reg_wen. Asserting rst during LS_WAIT clears all outputs asynchronously within the same cycle.
